writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Producer side of the three-write-port integer register file.
- Collects completed results from NUM_SRC functional units (ALU, MUL, DIV, LSU) over valid/ready handshakes.
- Buffers one result per unit and arbitrates up to three writes per cycle, round-robin.
- Drives the register file's rd/write_data/write_en port triplets.
- Reports per-unit write completion to the scoreboard.

Parameters:
- NUM_SRC, 4: number of functional-unit result sources; legal range 3..8.
- DATA_W, 32: result data width.
- ADDR_W, 5: destination register index width.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- src_valid, input, NUM_SRC: per-unit result valid.
- src_rd, input, NUM_SRC*ADDR_W: per-unit destination index, unit i at bits [i*ADDR_W +: ADDR_W].
- src_data, input, NUM_SRC*DATA_W: per-unit result data, same packing.
- src_ready, output, NUM_SRC: per-unit holding buffer can accept.
- wb_rd1 / wb_rd2 / wb_rd3, output, ADDR_W each: register file write indices.
- wb_data1 / wb_data2 / wb_data3, output, DATA_W each: register file write data.
- wb_en1 / wb_en2 / wb_en3, output, 1 each: register file write enables.
- wb_done, output, NUM_SRC: one-cycle pulse per unit whose result retired this cycle.
- busy, output, 1: any holding buffer occupied.

Behaviour:
Reset:
- All holding buffers empty; rr_ptr = 0.
- wb_en1..3 = 0; wb_rd* = 0; wb_data* = 0; wb_done = 0; busy = 0.
- src_ready = all ones, one cycle after rst deasserts.
- Reset mid-operation drops all buffered results; the scoreboard must reissue.

Holding buffers:
- Transfer occurs on src_valid & src_ready at a clk edge.
- src_ready[i] = buffer i empty OR buffer i granted this cycle, so a full-throughput back-to-back handoff is possible.
- The buffer captures rd and data at the edge of transfer.

Arbitration (combinational over occupied buffers):
- Scan starts at rr_ptr and wraps modulo NUM_SRC.
- Grant the first three occupied buffers whose rd is nonzero.
- Destination conflict: an entry whose rd equals an already-granted rd in the same scan is skipped and stays buffered, so no two ports ever carry the same nonzero rd.
- Entries with rd == 0 are drained in the same cycle without consuming a port, and set wb_done without any wb_en.
- Grants are assigned to ports in scan order: first grant to port 1, second to port 2, third to port 3.

Outputs (registered):
- At the edge following a grant, wb_rd*/wb_data*/wb_en* load the granted entries; unused ports get wb_en = 0.
- wb_rd/wb_data of unused ports hold their previous value.
- wb_done[i] pulses in the same cycle that the entry's wb_en is high.

Latency: result accepted at edge T, visible on wb_* after edge T+1, written into the register file at edge T+2.

rr_ptr update:
- Becomes (index of last granted or drained source + 1) mod NUM_SRC.
- Unchanged if nothing was granted.
- Guarantees each occupied source is granted within ceil(NUM_SRC/3)+1 cycles, absent conflicts.

Simultaneous events:
- Fill and drain of the same buffer in one cycle is legal: the new entry replaces the old.
- All NUM_SRC buffers may be occupied; excess entries wait.

busy = OR of buffer occupancy flags.

Optional Feature:
WRITEBACK_ARBITER_FWD_EN
- With the macro: adds inputs fwd_rs1 and fwd_rs2 (ADDR_W each) and outputs fwd_hit1, fwd_hit2 (1 each) and fwd_data1, fwd_data2 (DATA_W each).
- A hit is a combinational match against the registered wb ports with wb_en = 1 and nonzero rd.
- Since at most one port matches, the matching port's data is returned; with no hit, data = 0.
- This covers the register file's one-cycle write-then-read window.
- Without the macro: these ports and their logic are absent.

Decomposition:
- Package wb_pkg holds: WB_PORTS = 3, ADDR_W, DATA_W, source index constants (SRC_ALU = 0, SRC_MUL = 1, SRC_DIV = 2, SRC_LSU = 3) and the entry struct {rd, data}.
- Sub-module wb_hold_buf: one-entry buffer with valid/ready in and grant/clear out, instantiated NUM_SRC times.
- The arbiter scan and rr_ptr logic stay in the top.

Test Plan:
- Reset: assert rst with buffers full → same cycle wb_en* = 0, busy = 0; after release src_ready = 4'b1111.
- Single result: ALU rd = 5, data = 0xDEADBEEF at edge T → wb_en1 = 1, wb_rd1 = 5, wb_data1 = 0xDEADBEEF after edge T+1; wb_done = 4'b0001 in the same cycle.
- Four simultaneous results: rd 1/2/3/4 with rr_ptr = 0 → cycle 1 writes rd 1, 2, 3 on ports 1–3; cycle 2 writes rd 4 on port 1; rr_ptr then = 0.
- Destination conflict: ALU and MUL both rd = 7 → first cycle grants only ALU; MUL writes rd 7 the next cycle; never two wb_en with rd 7 together.
- rd zero: LSU rd = 0, data = 0x1 → wb_done[3] pulses, no wb_en asserted, buffer freed.
- Back-to-back: ALU src_valid held high 10 cycles with rd = 1..10 → src_ready stays 1 and ten consecutive wb_en1 pulses carry rd 1..10.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, source indices and the buffered result entry for the writeback arbiter.
package wb_pkg;
    localparam int WB_PORTS = 3;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam int SRC_ALU  = 0;
    localparam int SRC_MUL  = 1;
    localparam int SRC_DIV  = 2;
    localparam int SRC_LSU  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Functional-unit result handshakes and the three register-file write ports.
// Forwarding signals exist only when WRITEBACK_ARBITER_FWD_EN is defined.
interface writeback_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = wb_pkg::DATA_W,
    parameter int ADDR_W  = wb_pkg::ADDR_W
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*ADDR_W-1:0] src_rd;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic [ADDR_W-1:0]         wb_rd1, wb_rd2, wb_rd3;
    logic [DATA_W-1:0]         wb_data1, wb_data2, wb_data3;
    logic                      wb_en1, wb_en2, wb_en3;
    logic [NUM_SRC-1:0]        wb_done;
    logic                      busy;
`ifdef WRITEBACK_ARBITER_FWD_EN
    logic [ADDR_W-1:0]         fwd_rs1, fwd_rs2;
    logic                      fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0]         fwd_data1, fwd_data2;
`endif

    modport slave (
        input  src_valid, src_rd, src_data,
        output src_ready, wb_rd1, wb_rd2, wb_rd3, wb_data1, wb_data2, wb_data3,
        output wb_en1, wb_en2, wb_en3, wb_done, busy
`ifdef WRITEBACK_ARBITER_FWD_EN
        , input fwd_rs1, fwd_rs2, output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport master (
        output src_valid, src_rd, src_data,
        input  src_ready, wb_rd1, wb_rd2, wb_rd3, wb_data1, wb_data2, wb_data3,
        input  wb_en1, wb_en2, wb_en3, wb_done, busy
`ifdef WRITEBACK_ARBITER_FWD_EN
        , output fwd_rs1, fwd_rs2, input fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );
endinterface

// File: rtl/writeback_arbiter_hold_buf.sv
// One-entry result buffer; capture on vld&rdy, freed by grant. Ready is high when empty
// or granted this cycle, so a granted entry can be replaced in the same edge.
module wb_hold_buf import wb_pkg::*; #(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_vld,
    input  entry_t i_entry,
    output logic   o_rdy,
    input  logic   i_grant,
    output logic   o_vld,
    output entry_t o_entry
);
    logic   r_vld;
    entry_t r_entry;

    assign o_rdy   = ~r_vld | i_grant;
    assign o_vld   = r_vld;
    assign o_entry = r_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_entry <= '0;
        end else if (i_vld && o_rdy) begin
            r_vld   <= 1'b1;
            r_entry <= i_entry;
        end else if (i_grant) begin
            r_vld   <= 1'b0;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback of NUM_SRC buffered results onto three register-file ports, 1 cycle
// buffer-to-port; optional forwarding via WRITEBACK_ARBITER_FWD_EN. Units stall only while their buffer is held.
module writeback_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = wb_pkg::DATA_W,
    parameter int ADDR_W  = wb_pkg::ADDR_W
) (
    input  logic clk,
    input  logic rst,
    writeback_arbiter_if.slave bus
);
    import wb_pkg::*;

    localparam int PTR_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [NUM_SRC-1:0] w_buf;
    logic   [NUM_SRC-1:0] w_occ, w_grant, w_ready;
    logic   [PTR_W-1:0]   r_rr_ptr, w_idx, w_last, w_next_ptr;
    logic   [PTR_W:0]     w_sum;
    logic   [1:0]         w_nport;
    logic                 w_any, w_conflict;
    logic   [PTR_W-1:0]   w_port_src [WB_PORTS];
    logic   [ADDR_W-1:0]  w_port_rd  [WB_PORTS];

    logic   [WB_PORTS-1:0] r_wb_en;
    logic   [ADDR_W-1:0]   r_wb_rd   [WB_PORTS];
    logic   [DATA_W-1:0]   r_wb_data [WB_PORTS];
    logic   [NUM_SRC-1:0]  r_wb_done;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_buf
        entry_t w_in;
        assign w_in.rd   = bus.src_rd[i*ADDR_W +: ADDR_W];
        assign w_in.data = bus.src_data[i*DATA_W +: DATA_W];
        wb_hold_buf #(.entry_t(entry_t)) u_buf (
            .clk(clk), .rst(rst), .i_vld(bus.src_valid[i]), .i_entry(w_in),
            .o_rdy(w_ready[i]), .i_grant(w_grant[i]), .o_vld(w_occ[i]), .o_entry(w_buf[i])
        );
    end

    // Scan from rr_ptr; rd==0 drains without a port, a repeated nonzero rd waits a cycle.
    always_comb begin
        w_grant    = '0;
        w_nport    = '0;
        w_any      = 1'b0;
        w_last     = '0;
        w_sum      = '0;
        w_idx      = '0;
        w_conflict = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            w_port_src[p] = '0;
            w_port_rd[p]  = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_SRC))
                w_sum = w_sum - (PTR_W+1)'(NUM_SRC);
            w_idx = w_sum[PTR_W-1:0];
            if (w_occ[w_idx]) begin
                if (w_buf[w_idx].rd == '0) begin
                    w_grant[w_idx] = 1'b1;
                    w_any          = 1'b1;
                    w_last         = w_idx;
                end else if (w_nport != 2'(WB_PORTS)) begin
                    w_conflict = 1'b0;
                    for (int p = 0; p < WB_PORTS; p++)
                        if (2'(p) < w_nport && w_port_rd[p] == w_buf[w_idx].rd)
                            w_conflict = 1'b1;
                    if (!w_conflict) begin
                        w_grant[w_idx]      = 1'b1;
                        w_port_src[w_nport] = w_idx;
                        w_port_rd[w_nport]  = w_buf[w_idx].rd;
                        w_nport             = w_nport + 2'd1;
                        w_any               = 1'b1;
                        w_last              = w_idx;
                    end
                end
            end
        end
        w_next_ptr = (w_last == PTR_W'(NUM_SRC-1)) ? '0 : w_last + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_wb_en   <= '0;
            r_wb_done <= '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                r_wb_rd[p]   <= '0;
                r_wb_data[p] <= '0;
            end
        end else begin
            r_wb_done <= w_grant;
            if (w_any)
                r_rr_ptr <= w_next_ptr;
            for (int p = 0; p < WB_PORTS; p++) begin
                r_wb_en[p] <= (2'(p) < w_nport);
                if (2'(p) < w_nport) begin
                    r_wb_rd[p]   <= w_port_rd[p];
                    r_wb_data[p] <= w_buf[w_port_src[p]].data;
                end
            end
        end
    end

    assign bus.src_ready = w_ready;
    assign bus.busy      = |w_occ;
    assign bus.wb_done   = r_wb_done;
    assign bus.wb_en1    = r_wb_en[0];
    assign bus.wb_en2    = r_wb_en[1];
    assign bus.wb_en3    = r_wb_en[2];
    assign bus.wb_rd1    = r_wb_rd[0];
    assign bus.wb_rd2    = r_wb_rd[1];
    assign bus.wb_rd3    = r_wb_rd[2];
    assign bus.wb_data1  = r_wb_data[0];
    assign bus.wb_data2  = r_wb_data[1];
    assign bus.wb_data3  = r_wb_data[2];

`ifdef WRITEBACK_ARBITER_FWD_EN
    // Distinct nonzero rd per port means at most one port can match each read index.
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_data2 = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (r_wb_en[p] && r_wb_rd[p] != '0 && r_wb_rd[p] == bus.fwd_rs1) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = r_wb_data[p];
            end
            if (r_wb_en[p] && r_wb_rd[p] != '0 && r_wb_rd[p] == bus.fwd_rs2) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = r_wb_data[p];
            end
        end
    end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: a reference model predicts each cycle's port writes, a monitor compares them.
module tb_writeback_arbiter;
    localparam int NS = 4, DW = 32, AW = 5, NP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();
    writeback_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [NP-1:0]         en;
        logic [NP-1:0][AW-1:0] rd;
        logic [NP-1:0][DW-1:0] data;
        logic [NS-1:0]         done;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    bit          m_occ [NS];
    logic [AW-1:0] m_rd  [NS];
    logic [DW-1:0] m_dat [NS];
    int          m_rr;
    logic [AW-1:0] m_prd [NP];
    logic [DW-1:0] m_pdat[NP];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_occ[i] = 1'b0; m_rd[i] = '0; m_dat[i] = '0;
        end
        for (int p = 0; p < NP; p++) begin
            m_prd[p] = '0; m_pdat[p] = '0;
        end
        m_rr = 0;
    endtask

    // One clock of stimulus: predict this cycle's grants, check ready/busy, drive, queue expectation.
    task automatic drive_cycle(input logic [NS-1:0] v, input logic [NS*AW-1:0] rds,
                               input logic [NS*DW-1:0] dats);
        logic [NS-1:0] g;
        logic [NS-1:0] rdy;
        int   sel[$];
        int   last;
        bit   any;
        bit   clash;
        bit   occ_any;
        int   s;
        exp_t e;
        @(negedge clk);
        g = '0; any = 1'b0; last = 0; occ_any = 1'b0;
        for (int k = 0; k < NS; k++) begin
            s = (m_rr + k) % NS;
            if (m_occ[s]) begin
                occ_any = 1'b1;
                if (m_rd[s] == 0) begin
                    g[s] = 1'b1; any = 1'b1; last = s;
                end else if (sel.size() < NP) begin
                    clash = 1'b0;
                    foreach (sel[j]) if (m_rd[sel[j]] == m_rd[s]) clash = 1'b1;
                    if (!clash) begin
                        sel.push_back(s); g[s] = 1'b1; any = 1'b1; last = s;
                    end
                end
            end
        end
        for (int i = 0; i < NS; i++) rdy[i] = !m_occ[i] || g[i];
        chk("src_ready", bus.src_ready, rdy);
        chk("busy", bus.busy, occ_any);
        bus.src_valid = v;
        bus.src_rd    = rds;
        bus.src_data  = dats;
        e.en = '0;
        for (int p = 0; p < NP; p++) begin
            if (p < sel.size()) begin
                e.en[p]  = 1'b1;
                m_prd[p] = m_rd[sel[p]];
                m_pdat[p] = m_dat[sel[p]];
            end
            e.rd[p]   = m_prd[p];
            e.data[p] = m_pdat[p];
        end
        e.done = g;
        exp_q.push_back(e);
        for (int i = 0; i < NS; i++) begin
            if (v[i] && rdy[i]) begin
                m_occ[i] = 1'b1;
                m_rd[i]  = rds[i*AW +: AW];
                m_dat[i] = dats[i*DW +: DW];
            end else if (g[i]) begin
                m_occ[i] = 1'b0;
            end
        end
        if (any) m_rr = (last + 1) % NS;
    endtask

    task automatic idle();
        drive_cycle('0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.src_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst_wb_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.wb_done, 4'b0000);
        chk("rst_rd_data", {bus.wb_rd1, bus.wb_data1, bus.wb_rd3, bus.wb_data3}, '0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", bus.src_ready, 4'b1111);
    endtask

    // Monitor: one queued expectation per clock after reset, plus a port-uniqueness invariant.
    initial begin
        forever begin
            exp_t e;
            exp_t a;
            bit dup;
            @(posedge clk); #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.en      = {bus.wb_en3, bus.wb_en2, bus.wb_en1};
                a.rd[0]   = bus.wb_rd1;   a.rd[1]   = bus.wb_rd2;   a.rd[2]   = bus.wb_rd3;
                a.data[0] = bus.wb_data1; a.data[1] = bus.wb_data2; a.data[2] = bus.wb_data3;
                a.done    = bus.wb_done;
                chk("wb_ports", a, e);
                dup = 1'b0;
                for (int p = 0; p < NP; p++)
                    for (int q = p + 1; q < NP; q++)
                        if (a.en[p] && a.en[q] && a.rd[p] == a.rd[q]) dup = 1'b1;
                chk("rd_unique", dup, 1'b0);
            end
        end
    end

`ifdef WRITEBACK_ARBITER_FWD_EN
    initial begin
        bus.fwd_rs1 = '0;
        bus.fwd_rs2 = '0;
    end
`endif

    initial begin
        logic [NS-1:0]    v;
        logic [NS*AW-1:0] rds;
        logic [NS*DW-1:0] dats;
        bus.src_valid = '0;
        bus.src_rd    = '0;
        bus.src_data  = '0;
        model_reset();
        #2;
        do_reset();

        // Single ALU result rd=5
        drive_cycle(4'b0001, 20'd5, {96'd0, 32'hDEADBEEF});
        idle();
        @(posedge clk); #1;
        chk("single_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b001);
        chk("single_rd", bus.wb_rd1, 5'd5);
        chk("single_data", bus.wb_data1, 32'hDEADBEEF);
        chk("single_done", bus.wb_done, 4'b0001);

        // Four results from rr_ptr 0, then a full buffer set interrupted by reset
        do_reset();
        drive_cycle(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11});
        idle();
        @(posedge clk); #1;
        chk("four_c1_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b111);
        chk("four_c1_rd", {bus.wb_rd3, bus.wb_rd2, bus.wb_rd1}, {5'd3, 5'd2, 5'd1});
        idle();
        @(posedge clk); #1;
        chk("four_c2_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b001);
        chk("four_c2_rd", {bus.wb_rd1, bus.wb_data1, bus.wb_done}, {5'd4, 32'h44, 4'b1000});

        // Destination conflict: ALU and MUL both rd=7
        drive_cycle(4'b0011, {10'd0, 5'd7, 5'd7}, {64'd0, 32'hB, 32'hA});
        idle();
        @(posedge clk); #1;
        chk("conf_c1", {bus.wb_en3, bus.wb_en2, bus.wb_en1, bus.wb_rd1, bus.wb_data1, bus.wb_done},
            {3'b001, 5'd7, 32'hA, 4'b0001});
        idle();
        @(posedge clk); #1;
        chk("conf_c2", {bus.wb_en3, bus.wb_en2, bus.wb_en1, bus.wb_rd1, bus.wb_data1, bus.wb_done},
            {3'b001, 5'd7, 32'hB, 4'b0010});

        // LSU rd=0 drains with no port write
        drive_cycle(4'b1000, '0, {32'h1, 96'd0});
        idle();
        @(posedge clk); #1;
        chk("rd0_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b000);
        chk("rd0_done", bus.wb_done, 4'b1000);
        chk("rd0_busy", bus.busy, 1'b0);

        // Back-to-back ALU stream rd 1..10
        for (int i = 1; i <= 10; i++)
            drive_cycle(4'b0001, {15'd0, 5'(i)}, {96'd0, 32'(i * 32'h101)});
        repeat (3) idle();

        // Reset while ports are active and one buffer is still full
        drive_cycle(4'b1111, {5'd12, 5'd11, 5'd10, 5'd9}, {32'hC, 32'hB, 32'hA, 32'h9});
        idle();
        @(posedge clk); #1;
        chk("pre_rst_busy", bus.busy, 1'b1);
        chk("pre_rst_en", {bus.wb_en3, bus.wb_en2, bus.wb_en1}, 3'b111);
        do_reset();

        // Randomized traffic with small rd range to provoke conflicts and rd=0 drains
        for (int c = 0; c < 400; c++) begin
            v = NS'($urandom);
            for (int i = 0; i < NS; i++) begin
                rds[i*AW +: AW]  = AW'($urandom_range(0, 7));
                dats[i*DW +: DW] = $urandom;
            end
            drive_cycle(v, rds, dats);
            if (c == 200) do_reset();
        end
        repeat (6) idle();
        @(posedge clk); #2;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
